// File: rtl/knight_rider_monitor.sv
// knight_rider_monitor: decodes a one-hot scanner LED bus into position, direction, rate code and protocol errors
module knight_rider_monitor #(
  parameter int WIDTH    = 8,
  parameter int CLK_FREQ = 6000,
  parameter int PERIOD_W = 14
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         led_in,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     dir,
  output logic [2:0]               rate_code,
  output logic                     locked,
  output logic                     step_pulse,
  output logic                     err_onehot,
  output logic                     err_step,
  output logic                     err_sticky
);
  localparam int PW = $clog2(WIDTH);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SEEK, MEASURE, TRACK} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    led_q, led_prev_q;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, last_q, last_d, period;
  logic [PW-1:0]       pos_q, pos_d, idx;
  logic [2:0]          rate_q, rate_d, code;
  logic                dir_q, dir_d, locked_q, locked_d, step_q, step_d;
  logic                eoh_q, eoh_d, estep_q, estep_d, sticky_q, sticky_d;
  logic                oh, step, left, right, legal, timeout;

  function automatic logic [2:0] classify(input logic [PERIOD_W-1:0] p);
    return p == PERIOD_W'(2 * CLK_FREQ) ? 3'd0 :
           p == PERIOD_W'(CLK_FREQ)     ? 3'd1 :
           p == PERIOD_W'(CLK_FREQ / 2) ? 3'd2 :
           p == PERIOD_W'(CLK_FREQ / 4) ? 3'd3 :
           p == PERIOD_W'(CLK_FREQ / 8) ? 3'd4 : 3'd7;
  endfunction

  // index of the lit LED in led_q (only meaningful when led_q is one-hot)
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) if (led_q[i]) idx = PW'(i);
  end

  // step legality, period measurement and tracking state machine
  always_comb begin
    oh       = $onehot(led_q);
    step     = oh && $onehot(led_prev_q) && led_q != led_prev_q;
    left     = led_q == (led_prev_q << 1);
    right    = led_q == (led_prev_q >> 1);
    period   = cnt_q == CNT_MAX ? CNT_MAX : cnt_q + 1'b1;
    code     = classify(period);
    legal    = state_q == SEEK ? left || right :
               left ? dir_q || led_prev_q[0] : right && (!dir_q || led_prev_q[WIDTH-1]);
    timeout  = (state_q == MEASURE || state_q == TRACK) && cnt_q == CNT_MAX;
    state_d  = state_q;
    cnt_d    = step ? '0 : cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1;
    last_d   = last_q;
    pos_d    = oh ? idx : pos_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    rate_d   = rate_q;
    step_d   = 1'b0;
    eoh_d    = 1'b0;
    estep_d  = 1'b0;
    if (!oh) begin
      if (state_q != IDLE) begin
        eoh_d    = 1'b1;
        locked_d = 1'b0;
        rate_d   = 3'd7;
      end
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      state_d = SEEK;
    end else if (step && legal) begin
      step_d  = 1'b1;
      dir_d   = left;
      state_d = state_q == SEEK ? MEASURE : TRACK;
      if (state_q != SEEK) begin
        last_d = period;
        rate_d = code;
      end
      if (state_q == TRACK) locked_d = period == last_q && code != 3'd7;
    end else if (step) begin
      estep_d  = 1'b1;
      state_d  = SEEK;
      locked_d = 1'b0;
      rate_d   = 3'd7;
    end else if (timeout) begin
      state_d  = SEEK;
      locked_d = 1'b0;
      rate_d   = 3'd7;
    end
    sticky_d = sticky_q | eoh_d | estep_d;
  end

  // input sampling and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q      <= '0;
      led_prev_q <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= '0;
      pos_q      <= '0;
      dir_q      <= 1'b1;
      rate_q     <= 3'd7;
      locked_q   <= 1'b0;
      step_q     <= 1'b0;
      eoh_q      <= 1'b0;
      estep_q    <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      led_q      <= led_in;
      led_prev_q <= led_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      rate_q     <= rate_d;
      locked_q   <= locked_d;
      step_q     <= step_d;
      eoh_q      <= eoh_d;
      estep_q    <= estep_d;
      sticky_q   <= sticky_d;
    end
  end

  assign pos        = pos_q;
  assign dir        = dir_q;
  assign rate_code  = rate_q;
  assign locked     = locked_q;
  assign step_pulse = step_q;
  assign err_onehot = eoh_q;
  assign err_step   = estep_q;
  assign err_sticky = sticky_q;
endmodule

// File: tb/tb_knight_rider_monitor.sv
// tb_knight_rider_monitor: directed and random LED traffic against a position-based reference model
module tb_knight_rider_monitor;
  localparam int W    = 8;
  localparam int CF   = 6000;
  localparam int MAXC = 16383;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] led_in = '0;
  logic [2:0] pos, rate_code;
  logic       dir, locked, step_pulse, err_onehot, err_step, err_sticky;
  int         checks = 0;
  int         failures = 0;

  knight_rider_monitor #(.WIDTH(W), .CLK_FREQ(CF), .PERIOD_W(14)) dut (
    .clk(clk), .reset_n(reset_n), .led_in(led_in), .pos(pos), .dir(dir),
    .rate_code(rate_code), .locked(locked), .step_pulse(step_pulse),
    .err_onehot(err_onehot), .err_step(err_step), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx(input logic [7:0] v);
    int r = -1;
    for (int i = 0; i < W; i++) if (v[i]) r = i;
    return $countones(v) == 1 ? r : -1;
  endfunction

  function automatic logic [2:0] cls(input int p);
    if (p == 2 * CF) return 3'd0;
    if (p == CF)     return 3'd1;
    if (p == CF / 2) return 3'd2;
    if (p == CF / 4) return 3'd3;
    if (p == CF / 8) return 3'd4;
    return 3'd7;
  endfunction

  // reference model: phase -1 no position, 0 position known, 1 one step seen, 2 tracking
  logic [7:0] m_led = '0, m_prev = '0;
  int         phase = -1, age = 0, last_per = 0, p, q, per;
  bit         stepping, stale, ok;
  logic [2:0] e_pos = '0, e_rate = 3'd7;
  logic       e_dir = 1'b1, e_locked = 1'b0, e_step = 1'b0, e_eoh = 1'b0, e_estep = 1'b0, e_sticky = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_led = '0; m_prev = '0; phase = -1; age = 0; last_per = 0;
      e_pos = '0; e_dir = 1'b1; e_rate = 3'd7; e_locked = 1'b0;
      e_step = 1'b0; e_eoh = 1'b0; e_estep = 1'b0; e_sticky = 1'b0;
    end else begin
      e_step = 1'b0; e_eoh = 1'b0; e_estep = 1'b0;
      p = idx(m_led);
      q = idx(m_prev);
      stepping = p >= 0 && q >= 0 && p != q;
      per = age + 1 > MAXC ? MAXC : age + 1;
      stale = age >= MAXC;
      age = stepping ? 0 : age + 1;
      if (p < 0) begin
        if (phase >= 0) begin e_eoh = 1'b1; e_locked = 1'b0; e_rate = 3'd7; end
        phase = -1;
      end else begin
        e_pos = 3'(p);
        if (phase < 0) phase = 0;
        else if (stepping) begin
          ok = (p - q == 1 || q - p == 1) &&
               (phase == 0 || ((p > q) == e_dir) || (p > q ? q == 0 : q == W - 1));
          if (ok) begin
            e_step = 1'b1;
            e_dir = p > q;
            if (phase == 2) e_locked = per == last_per && cls(per) != 3'd7;
            if (phase >= 1) begin last_per = per; e_rate = cls(per); end
            phase = phase == 0 ? 1 : 2;
          end else begin
            e_estep = 1'b1; phase = 0; e_locked = 1'b0; e_rate = 3'd7;
          end
        end else if (phase >= 1 && stale) begin
          phase = 0; e_locked = 1'b0; e_rate = 3'd7;
        end
      end
      e_sticky = e_sticky | e_eoh | e_estep;
      m_prev = m_led;
      m_led = led_in;
    end
  end

  // every cycle out of reset, all outputs must match the model
  always @(negedge clk)
    if (reset_n)
      check("model", 32'({pos, dir, rate_code, locked, step_pulse, err_onehot, err_step, err_sticky}),
                     32'({e_pos, e_dir, e_rate, e_locked, e_step, e_eoh, e_estep, e_sticky}));

  task automatic step_to(input logic [7:0] v, input int gap);
    led_in = v;
    repeat (gap) @(negedge clk);
  endtask

  task automatic expect_state(input string tag, input int ep, input int ed, input int er, input int el);
    check({tag, "_pos"}, 32'(pos), ep);
    check({tag, "_dir"}, 32'(dir), ed);
    check({tag, "_rate"}, 32'(rate_code), er);
    check({tag, "_locked"}, 32'(locked), el);
  endtask

  task automatic expect_reset(input string tag);
    expect_state(tag, 0, 1, 7, 0);
    check({tag, "_pulses_sticky"}, 32'({step_pulse, err_onehot, err_step, err_sticky}), 0);
  endtask

  initial begin
    int rp, r, np, gap;
    logic [7:0] v;
    repeat (3) @(negedge clk);
    expect_reset("reset");
    reset_n = 1'b1;
    step_to(8'h01, 16500);
    expect_state("seek", 0, 1, 7, 0);
    check("seek_sticky", 32'(err_sticky), 0);
    step_to(8'h02, 3000);
    step_to(8'h04, 3000);
    expect_state("slow2", 2, 1, 2, 0);
    step_to(8'h08, 3000);
    expect_state("slow3", 3, 1, 2, 1);
    for (int i = 4; i < 8; i++) step_to(8'(1 << i), 750);
    for (int i = 6; i >= 0; i--) begin
      step_to(8'(1 << i), 750);
      if (i == 6) check("bounce_top_dir", 32'(dir), 0);
    end
    step_to(8'h02, 750);
    expect_state("fast", 1, 1, 4, 1);
    step_to(8'h04, 5000);
    step_to(8'h08, 12000);
    expect_state("odd", 3, 1, 7, 0);
    step_to(8'h10, 12000);
    expect_state("vslow1", 4, 1, 0, 0);
    step_to(8'h20, 3);
    expect_state("vslow2", 5, 1, 0, 1);
    repeat (16400) @(negedge clk);
    expect_state("timeout", 5, 1, 7, 0);
    check("timeout_sticky", 32'(err_sticky), 0);
    step_to(8'h40, 750);
    step_to(8'h80, 750);
    step_to(8'h40, 5);
    expect_state("relock1", 6, 0, 4, 1);
    led_in = 8'h05;
    @(negedge clk);
    led_in = 8'h08;
    @(negedge clk);
    check("eoh_pulse", 32'(err_onehot), 1);
    expect_state("eoh", 6, 0, 7, 0);
    check("eoh_sticky", 32'(err_sticky), 1);
    @(negedge clk);
    check("eoh_end", 32'(err_onehot), 0);
    check("eoh_return_pos", 32'(pos), 3);
    step_to(8'h10, 750);
    step_to(8'h20, 750);
    step_to(8'h40, 5);
    check("relock2", 32'(locked), 1);
    led_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("zero_pulse", 32'(err_onehot), 1);
    check("zero_locked", 32'(locked), 0);
    @(negedge clk);
    check("zero_end", 32'(err_onehot), 0);
    step_to(8'h08, 3);
    check("zero_return_pos", 32'(pos), 3);
    step_to(8'h04, 10);
    led_in = 8'h10;
    @(negedge clk);
    @(negedge clk);
    check("jump_estep_step", 32'({err_step, step_pulse}), 2);
    check("jump_pos", 32'(pos), 4);
    @(negedge clk);
    check("jump_end", 32'(err_step), 0);
    step_to(8'h04, 10);
    step_to(8'h08, 10);
    check("pre_rev_dir", 32'(dir), 1);
    led_in = 8'h04;
    @(negedge clk);
    @(negedge clk);
    check("rev_estep_step", 32'({err_step, step_pulse}), 2);
    check("rev_pos_dir", 32'({pos, dir}), 5);
    @(negedge clk);
    check("rev_end", 32'(err_step), 0);
    led_in = 8'h08;
    @(negedge clk);
    @(negedge clk);
    check("seek_accepts_step", 32'(step_pulse), 1);
    for (int n = 0; n < 40; n++) begin
      rp = idx(led_in) < 0 ? 0 : idx(led_in);
      r = $urandom_range(0, 99);
      if (r < 60) begin
        np = $urandom_range(0, 1) ? rp + 1 : rp - 1;
        np = np < 0 ? 1 : np > W - 1 ? W - 2 : np;
        v = 8'(1 << np);
      end else if (r < 75) v = 8'(1 << $urandom_range(0, W - 1));
      else if (r < 85) v = 8'($urandom_range(0, 255));
      else v = led_in;
      gap = $urandom_range(0, 9) < 2 ? 750 : $urandom_range(1, 12);
      step_to(v, gap);
    end
    step_to(8'h01, 20);
    step_to(8'h02, 20);
    step_to(8'h04, 20);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 expect_reset("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    step_to(8'h01, 5);
    led_in = 8'h02;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_step", 32'({step_pulse, pos}), 9);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
